mem_stage: RTL and testbench

- Memory stage of the 16-bit in-order pipeline; sits directly downstream of the execute stage.
- Consumes the ALU result, the store data (RD operand) and the destination register index.
- Performs load/store on the data bus using a req/ack handshake, with a timeout.
- Holds the pipeline via mem_stall while an access is outstanding, and presents a registered writeback bundle to the WB stage.

---
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: drives load/store onto the data bus and registers the writeback bundle for WB.
// Latency: 1 cycle for ALU ops, 2 cycles minimum for memory ops (plus bus wait states).
// Backpressure: mem_stall holds EX/ID while an access is being issued or is outstanding.
module mem_stage #(
    parameter int CPU_WIDTH = 16,
    parameter int REG_AW    = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 flush,
    input  logic [CPU_WIDTH-1:0] ALUout,
    input  logic [CPU_WIDTH-1:0] RD,
    input  logic [REG_AW-1:0]    rd_addr,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 RegWrite,
    output logic                 mem_stall,
    output logic                 dbus_req,
    output logic                 dbus_we,
    output logic [CPU_WIDTH-1:0] dbus_addr,
    output logic [CPU_WIDTH-1:0] dbus_wdata,
    input  logic [CPU_WIDTH-1:0] dbus_rdata,
    input  logic                 dbus_ack,
    output logic                 wb_valid,
    output logic                 wb_en,
    output logic [REG_AW-1:0]    wb_addr,
    output logic [CPU_WIDTH-1:0] wb_data,
    output logic                 bus_fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [REG_AW-1:0]     dst_addr_q;
    logic                  dst_wen_q;
    logic                  dbus_req_q;
    logic                  dbus_we_q;
    logic [CPU_WIDTH-1:0]  dbus_addr_q;
    logic [CPU_WIDTH-1:0]  dbus_wdata_q;
    logic                  wb_valid_q;
    logic                  wb_en_q;
    logic [REG_AW-1:0]     wb_addr_q;
    logic [CPU_WIDTH-1:0]  wb_data_q;
    logic                  bus_fault_q;

    logic accept;
    logic mem_op;

    assign accept    = (state_q == IDLE) && in_valid && !flush;
    assign mem_op    = MemRead || MemWrite;
    // Stall on the issue cycle too, so EX never moves past a memory op before it is latched.
    assign mem_stall = (state_q == ACCESS) || (accept && mem_op);

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_wdata = dbus_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_en      = wb_en_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign bus_fault  = bus_fault_q;

    // Access FSM with registered bus and writeback outputs; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dst_addr_q   <= '0;
            dst_wen_q    <= 1'b0;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            bus_fault_q  <= 1'b0;
        end else begin
            wb_valid_q  <= 1'b0;
            bus_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (mem_op) begin
                            state_q      <= ACCESS;
                            cnt_q        <= '0;
                            dbus_req_q   <= 1'b1;
                            dbus_we_q    <= MemWrite;
                            dbus_addr_q  <= ALUout;
                            dbus_wdata_q <= RD;
                            dst_addr_q   <= rd_addr;
                            // A store (even with MemRead also set) never writes a register.
                            dst_wen_q    <= RegWrite && !MemWrite;
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_en_q    <= RegWrite;
                            wb_addr_q  <= rd_addr;
                            wb_data_q  <= ALUout;
                        end
                    end
                end
                ACCESS: begin
                    if (dbus_ack) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        dbus_req_q <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= dst_addr_q;
                        if (dbus_we_q) begin
                            wb_en_q   <= 1'b0;
                            wb_data_q <= dbus_addr_q;
                        end else begin
                            wb_en_q   <= dst_wen_q;
                            wb_data_q <= dbus_rdata;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // Give up: retire the instruction without a register write.
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        dbus_req_q  <= 1'b0;
                        bus_fault_q <= 1'b1;
                        wb_valid_q  <= 1'b1;
                        wb_en_q     <= 1'b0;
                        wb_addr_q   <= dst_addr_q;
                        wb_data_q   <= dbus_addr_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] ALUout = '0;
    logic [15:0] RD = '0;
    logic [2:0]  rd_addr = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        RegWrite = 1'b0;
    logic        mem_stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [15:0] dbus_addr;
    logic [15:0] dbus_wdata;
    logic [15:0] dbus_rdata = '0;
    logic        dbus_ack = 1'b0;
    logic        wb_valid;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        bus_fault;

    mem_stage #(.CPU_WIDTH(16), .REG_AW(3), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .ALUout(ALUout), .RD(RD), .rd_addr(rd_addr),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .mem_stall(mem_stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .bus_fault(bus_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        fault;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every wb_valid pulse must match the oldest expected bundle.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            check("wb_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wb_en", 64'(wb_en), 64'(e.en));
                check("wb_addr", 64'(wb_addr), 64'(e.addr));
                check("bus_fault", 64'(bus_fault), 64'(e.fault));
                if (e.chk_data) check("wb_data", 64'(wb_data), 64'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 1'b0; flush = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    endtask

    task automatic issue(input logic fl, input logic [15:0] alu, input logic [15:0] rdv,
                         input logic [2:0] ra, input logic mr, input logic mw, input logic rw);
        in_valid = 1'b1; flush = fl; ALUout = alu; RD = rdv; rd_addr = ra;
        MemRead = mr; MemWrite = mw; RegWrite = rw;
    endtask

    // Runs the ACCESS phase for a bounded window; ack_at<0 means never ack.
    task automatic run_access(input string tag, input int ack_at, input logic [15:0] rdv,
                              input int window, input logic [15:0] ea, input logic ewe,
                              input logic [15:0] ewd, output int req_n, output int stall_n);
        req_n = 0; stall_n = 0;
        for (int c = 0; c < window; c++) begin
            @(negedge clk);
            if (dbus_req) req_n++;
            if (mem_stall) stall_n++;
            if (c == 0) begin
                check({tag, "_addr"}, 64'(dbus_addr), 64'(ea));
                check({tag, "_we"}, 64'(dbus_we), 64'(ewe));
                if (ewe) check({tag, "_wdata"}, 64'(dbus_wdata), 64'(ewd));
            end
            if (c == ack_at) begin dbus_ack = 1'b1; dbus_rdata = rdv; end
            step();
            dbus_ack = 1'b0;
            clear_in();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rq, st;

        // Reset state
        @(negedge clk);
        check("reset_outputs", 64'({dbus_req, dbus_we, dbus_addr, dbus_wdata, wb_valid,
                                   wb_en, wb_addr, wb_data, bus_fault}), 64'd0);
        check("reset_stall", 64'(mem_stall), 64'd0);
        step();
        rst = 1'b0;

        // ALU instruction: one-cycle writeback, no stall
        issue(1'b0, 16'h1234, 16'h0, 3'd3, 1'b0, 1'b0, 1'b1);
        sb.push_back('{en: 1'b1, addr: 3'd3, data: 16'h1234, fault: 1'b0, chk_data: 1'b1});
        @(negedge clk);
        check("alu_stall_issue", 64'(mem_stall), 64'd0);
        step();
        clear_in();
        @(negedge clk);
        check("alu_stall_after", 64'(mem_stall), 64'd0);
        step();

        // Load, ack after 2 wait cycles
        issue(1'b0, 16'h0040, 16'h0, 3'd5, 1'b1, 1'b0, 1'b1);
        sb.push_back('{en: 1'b1, addr: 3'd5, data: 16'hBEEF, fault: 1'b0, chk_data: 1'b1});
        @(negedge clk);
        check("ld_stall_issue", 64'(mem_stall), 64'd1);
        step();
        clear_in();
        run_access("ld", 2, 16'hBEEF, 5, 16'h0040, 1'b0, 16'h0, rq, st);
        check("ld_req_cycles", 64'(rq), 64'd3);
        check("ld_stall_total", 64'(st + 1), 64'd4);

        // Store, zero-wait ack; RegWrite set but a store never writes a register
        issue(1'b0, 16'h0010, 16'h00AA, 3'd2, 1'b0, 1'b1, 1'b1);
        sb.push_back('{en: 1'b0, addr: 3'd2, data: 16'h0010, fault: 1'b0, chk_data: 1'b1});
        @(negedge clk);
        check("st_stall_issue", 64'(mem_stall), 64'd1);
        step();
        clear_in();
        run_access("st", 0, 16'h0, 3, 16'h0010, 1'b1, 16'h00AA, rq, st);
        check("st_req_cycles", 64'(rq), 64'd1);
        check("st_stall_access", 64'(st), 64'd1);

        // MemRead & MemWrite together act as a store
        issue(1'b0, 16'h0022, 16'h0055, 3'd4, 1'b1, 1'b1, 1'b1);
        sb.push_back('{en: 1'b0, addr: 3'd4, data: 16'h0022, fault: 1'b0, chk_data: 1'b1});
        step();
        clear_in();
        run_access("rw", 1, 16'hDEAD, 4, 16'h0022, 1'b1, 16'h0055, rq, st);
        check("rw_req_cycles", 64'(rq), 64'd2);

        // Load that never acks: timeout after 15 request cycles
        issue(1'b0, 16'h0080, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1);
        sb.push_back('{en: 1'b0, addr: 3'd1, data: 16'h0, fault: 1'b1, chk_data: 1'b0});
        step();
        clear_in();
        run_access("to", -1, 16'h0, 15, 16'h0080, 1'b0, 16'h0, rq, st);
        check("to_req_cycles", 64'(rq), 64'd15);
        // Back-to-back ALU op accepted on the fault cycle
        issue(1'b0, 16'h7777, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1);
        sb.push_back('{en: 1'b1, addr: 3'd7, data: 16'h7777, fault: 1'b0, chk_data: 1'b1});
        @(negedge clk);
        check("to_req_dropped", 64'(dbus_req), 64'd0);
        check("to_next_stall", 64'(mem_stall), 64'd0);
        step();
        clear_in();
        @(negedge clk);
        check("to_fault_pulse", 64'(bus_fault), 64'd0);
        step();

        // Flushed load: no request, no writeback, no stall
        issue(1'b1, 16'h0100, 16'h0, 3'd6, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("fl_stall", 64'(mem_stall), 64'd0);
        step();
        clear_in();
        @(negedge clk);
        check("fl_no_req_wb", 64'({dbus_req, wb_valid}), 64'd0);
        step();

        // Flush during ACCESS leaves the access and its writeback intact
        issue(1'b0, 16'h0200, 16'h0, 3'd6, 1'b1, 1'b0, 1'b1);
        sb.push_back('{en: 1'b1, addr: 3'd6, data: 16'h5A5A, fault: 1'b0, chk_data: 1'b1});
        step();
        issue(1'b1, 16'hFFFF, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        run_access("flm", 1, 16'h5A5A, 4, 16'h0200, 1'b0, 16'h0, rq, st);
        check("flm_req_cycles", 64'(rq), 64'd2);

        // Reset two cycles into a load that would wait 5 cycles
        issue(1'b0, 16'h0300, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1);
        step();
        clear_in();
        step();
        step();
        @(negedge clk);
        check("rst_req_before", 64'(dbus_req), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_outputs_async", 64'({dbus_req, dbus_we, dbus_addr, dbus_wdata, wb_valid,
                                       wb_en, wb_addr, wb_data, bus_fault}), 64'd0);
        step();
        rst = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = 16'h9999;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_no_wb", 64'({dbus_req, wb_valid, bus_fault}), 64'd0);
            step();
            dbus_ack = 1'b0;
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
